mcd_wr_serializer: RTL

//  Upstream stage of the SSD write path. Accepts memcached write commands
//  (byte length) and 512-bit write-data beats, then emits the payload as a
//  32-bit valid/ready word stream into the write-data converter.
//  Per command, delivers the 32-bit word count (num_words + wr_num_words_en)

---
 rtl/mcd_wr_serializer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mcd_wr_serializer.sv
// mcd_wr_serializer: memcached write commands plus wide write beats in, 32-bit word stream out.
// Build macro WR_SER_BYTESWAP_EN byte-reverses every output word (SATA little-endian layout).
module mcd_wr_serializer #(
    parameter int IN_BITS  = 512,
    parameter int LEN_BITS = 16
) (
    input  logic                clk,
    input  logic                nReset,
    input  logic [LEN_BITS-1:0] cmd_len,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IN_BITS-1:0]  mcd_wr_data,
    input  logic                mcd_wr_valid,
    output logic                mcd_wr_ready,
    output logic [31:0]         dramWrData_data,
    output logic                dramWrData_valid,
    input  logic                dramWrData_ready,
    output logic [15:0]         num_words,
    output logic                wr_num_words_en
);
    localparam int WPB = IN_BITS / 32;
    localparam int CW  = $clog2(WPB) + 1;

    typedef enum logic [1:0] {IDLE, HDR, STREAM} state_t;
    state_t state, state_nxt;

    logic [IN_BITS-1:0] buf_data;
    logic [CW-1:0]      buf_cnt;
    logic [CW-1:0]      load_cnt;
    logic [15:0]        words_left;
    logic [15:0]        words_to_load;
    logic               cmd_start;
    logic               beat_fire;
    logic               word_fire;
    logic               last_word;

    // The +3 can carry out of LEN_BITS, so the sum is one bit wider.
    function automatic logic [15:0] word_count(input logic [LEN_BITS-1:0] len);
        logic [LEN_BITS:0] sum;
        sum = {1'b0, len} + (LEN_BITS+1)'(3);
        return 16'(sum >> 2);
    endfunction

`ifdef WR_SER_BYTESWAP_EN
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign dramWrData_data = byte_swap(buf_data[31:0]);
`else
    assign dramWrData_data = buf_data[31:0];
`endif

    assign cmd_start        = cmd_valid && cmd_ready && (cmd_len != '0);
    assign dramWrData_valid = (buf_cnt != '0);
    assign word_fire        = dramWrData_valid && dramWrData_ready;
    assign last_word        = word_fire && (buf_cnt == CW'(1));
    assign beat_fire        = mcd_wr_valid && mcd_wr_ready;
    assign load_cnt         = (words_to_load >= 16'(WPB)) ? CW'(WPB) : CW'(words_to_load);

    always_comb begin
        state_nxt       = state;
        cmd_ready       = 1'b0;
        mcd_wr_ready    = 1'b0;
        wr_num_words_en = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = nReset;
                if (cmd_valid && (cmd_len != '0))
                    state_nxt = HDR;
            end
            HDR: begin
                wr_num_words_en = 1'b1;
                state_nxt       = STREAM;
            end
            STREAM: begin
                // Refill as the last buffered word leaves, so beats stream without a bubble.
                mcd_wr_ready = (words_to_load != '0) && ((buf_cnt == '0) || last_word);
                if (word_fire && (words_left == 16'd1))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state         <= IDLE;
            buf_cnt       <= '0;
            num_words     <= '0;
            words_left    <= '0;
            words_to_load <= '0;
        end else begin
            state <= state_nxt;
            if (cmd_start)
                num_words <= word_count(cmd_len);
            if (state == HDR) begin
                words_left    <= num_words;
                words_to_load <= num_words;
            end
            if (word_fire)
                words_left <= words_left - 16'd1;
            if (beat_fire) begin
                buf_cnt       <= load_cnt;
                words_to_load <= words_to_load - 16'(load_cnt);
            end else if (word_fire) begin
                buf_cnt <= buf_cnt - CW'(1);
            end
        end
    end

    // Payload register carries no reset; buf_cnt alone decides what is valid.
    always_ff @(posedge clk) begin
        if (beat_fire)
            buf_data <= mcd_wr_data;
        else if (word_fire)
            buf_data <= buf_data >> 32;
    end

endmodule
